// File: rtl/iob_cache_be_arbiter_pkg.sv
// Shared constants and types for the cache back-end IOb arbiter: default widths,
// manager IDs and the arbitration state record.
package iob_cache_be_arbiter_pkg;

    localparam int unsigned ADDR_W_DEF      = 32;
    localparam int unsigned DATA_W_DEF      = 32;
    localparam int unsigned RID_DEPTH_W_DEF = 2;

    localparam logic M0_ID = 1'b0;
    localparam logic M1_ID = 1'b1;

    // The whole arbitration state lives in one struct so a checker can bind to it.
    typedef struct packed {
        logic lock;
        logic lock_id;
        logic last_win;
    } arb_state_t;

    localparam arb_state_t ARB_STATE_RST = '{lock: 1'b0, lock_id: M0_ID, last_win: M1_ID};

endpackage

// File: rtl/iob_cache_be_arb_rid_fifo.sv
// 1-bit wide FIFO of manager IDs for reads in flight; head names the owner of the
// next rvalid. Push when full and pop when empty are ignored.
module iob_cache_be_arb_rid_fifo #(
    parameter int unsigned DEPTH_W = 2
) (
    input  logic clk_i,
    input  logic cke_i,
    input  logic rst_i,
    input  logic push_i,
    input  logic data_i,
    input  logic pop_i,
    output logic head_o,
    output logic full_o,
    output logic empty_o
);

    localparam int unsigned DEPTH = 1 << DEPTH_W;

    logic [DEPTH-1:0]   r_mem;
    logic [DEPTH_W-1:0] r_wptr;
    logic [DEPTH_W-1:0] r_rptr;
    logic [DEPTH_W:0]   r_count;
    logic               w_push;
    logic               w_pop;

    // Count tops out at exactly DEPTH, the only value with the MSB set.
    assign full_o  = r_count[DEPTH_W];
    assign empty_o = (r_count == '0);
    assign head_o  = r_mem[r_rptr];
    assign w_push  = push_i & ~full_o;
    assign w_pop   = pop_i & ~empty_o;

    always_ff @(posedge clk_i) begin
        if (cke_i && w_push) begin
            r_mem[r_wptr] <= data_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else if (cke_i) begin
            if (w_push) r_wptr <= r_wptr + 1'b1;
            if (w_pop)  r_rptr <= r_rptr + 1'b1;
            unique case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/iob_cache_be_arbiter.sv
// Merges the I-cache (m0) and D-cache (m1) back-end IOb ports onto one memory port
// with round-robin arbitration, grant locking and read-response steering.
module iob_cache_be_arbiter
    import iob_cache_be_arbiter_pkg::*;
#(
    parameter int unsigned ADDR_W      = ADDR_W_DEF,
    parameter int unsigned DATA_W      = DATA_W_DEF,
    parameter int unsigned RID_DEPTH_W = RID_DEPTH_W_DEF
) (
    input  logic                clk_i,
    input  logic                cke_i,
    input  logic                rst_i,
    input  logic                m0_iob_valid_i,
    input  logic [ADDR_W-1:0]   m0_iob_addr_i,
    input  logic [DATA_W-1:0]   m0_iob_wdata_i,
    input  logic [DATA_W/8-1:0] m0_iob_wstrb_i,
    output logic                m0_iob_rvalid_o,
    output logic [DATA_W-1:0]   m0_iob_rdata_o,
    output logic                m0_iob_ready_o,
    input  logic                m1_iob_valid_i,
    input  logic [ADDR_W-1:0]   m1_iob_addr_i,
    input  logic [DATA_W-1:0]   m1_iob_wdata_i,
    input  logic [DATA_W/8-1:0] m1_iob_wstrb_i,
    output logic                m1_iob_rvalid_o,
    output logic [DATA_W-1:0]   m1_iob_rdata_o,
    output logic                m1_iob_ready_o,
    output logic                s_iob_valid_o,
    output logic [ADDR_W-1:0]   s_iob_addr_o,
    output logic [DATA_W-1:0]   s_iob_wdata_o,
    output logic [DATA_W/8-1:0] s_iob_wstrb_o,
    input  logic                s_iob_rvalid_i,
    input  logic [DATA_W-1:0]   s_iob_rdata_i,
    input  logic                s_iob_ready_i
);

    // Handshake: a request transfers in a cycle where valid and ready are both high;
    // a manager holds valid and its fields stable until it sees ready. Read data
    // returns later as a one-cycle rvalid pulse, in request order, with no back-pressure.

    arb_state_t r_state;
    arb_state_t w_state_nxt;
    logic [1:0] w_req_v;
    logic       w_gnt_id;
    logic       w_gnt_v;
    logic       w_gnt_read;
    logic       w_block;
    logic       w_hs;
    logic       w_push;
    logic       w_fifo_full;
    logic       w_fifo_empty;
    logic       w_fifo_head;

    assign w_req_v = {m1_iob_valid_i, m0_iob_valid_i};

    always_comb begin
        w_gnt_id = M1_ID;
        if (r_state.lock) begin
            w_gnt_id = r_state.lock_id;
        end else if (&w_req_v) begin
            w_gnt_id = ~r_state.last_win;
        end else if (w_req_v[M0_ID]) begin
            w_gnt_id = M0_ID;
        end
    end

    assign w_gnt_v       = w_req_v[w_gnt_id];
    assign s_iob_addr_o  = (w_gnt_id == M1_ID) ? m1_iob_addr_i  : m0_iob_addr_i;
    assign s_iob_wdata_o = (w_gnt_id == M1_ID) ? m1_iob_wdata_i : m0_iob_wdata_i;
    assign s_iob_wstrb_o = (w_gnt_id == M1_ID) ? m1_iob_wstrb_i : m0_iob_wstrb_i;

    // A read with no free ID slot must wait; full ignores a same-cycle pop.
    assign w_gnt_read    = (s_iob_wstrb_o == '0);
    assign w_block       = w_gnt_read & w_fifo_full;
    assign s_iob_valid_o = w_gnt_v & ~w_block;
    assign w_hs          = s_iob_valid_o & s_iob_ready_i;
    assign w_push        = w_hs & w_gnt_read;

    assign m0_iob_ready_o = w_hs & (w_gnt_id == M0_ID);
    assign m1_iob_ready_o = w_hs & (w_gnt_id == M1_ID);

    always_comb begin
        w_state_nxt = r_state;
        if (w_hs) begin
            w_state_nxt.lock     = 1'b0;
            w_state_nxt.last_win = w_gnt_id;
        end else if (s_iob_valid_o) begin
            w_state_nxt.lock    = 1'b1;
            w_state_nxt.lock_id = w_gnt_id;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= ARB_STATE_RST;
        end else if (cke_i) begin
            r_state <= w_state_nxt;
        end
    end

    iob_cache_be_arb_rid_fifo #(
        .DEPTH_W (RID_DEPTH_W)
    ) u_rid_fifo (
        .clk_i   (clk_i),
        .cke_i   (cke_i),
        .rst_i   (rst_i),
        .push_i  (w_push),
        .data_i  (w_gnt_id),
        .pop_i   (s_iob_rvalid_i),
        .head_o  (w_fifo_head),
        .full_o  (w_fifo_full),
        .empty_o (w_fifo_empty)
    );

    assign m0_iob_rvalid_o = s_iob_rvalid_i & ~w_fifo_empty & (w_fifo_head == M0_ID);
    assign m1_iob_rvalid_o = s_iob_rvalid_i & ~w_fifo_empty & (w_fifo_head == M1_ID);
    assign m0_iob_rdata_o  = s_iob_rdata_i;
    assign m1_iob_rdata_o  = s_iob_rdata_i;

    // A response with no read outstanding has no owner and is dropped.
    rvalid_has_owner: assert property (@(posedge clk_i) disable iff (rst_i)
        !(cke_i && s_iob_rvalid_i && w_fifo_empty));

endmodule

// File: tb/tb_iob_cache_be_arbiter.sv
// Bench for iob_cache_be_arbiter: directed scenarios plus random traffic, all checked
// against a reference model built from the arbitration rules and per-manager queues.
module tb_iob_cache_be_arbiter;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
    localparam int DEPTH  = 4;

    logic                clk_i = 1'b0;
    logic                cke_i, rst_i;
    logic                m0_iob_valid_i, m1_iob_valid_i;
    logic [ADDR_W-1:0]   m0_iob_addr_i, m1_iob_addr_i;
    logic [DATA_W-1:0]   m0_iob_wdata_i, m1_iob_wdata_i;
    logic [DATA_W/8-1:0] m0_iob_wstrb_i, m1_iob_wstrb_i;
    logic                m0_iob_rvalid_o, m1_iob_rvalid_o;
    logic [DATA_W-1:0]   m0_iob_rdata_o, m1_iob_rdata_o;
    logic                m0_iob_ready_o, m1_iob_ready_o;
    logic                s_iob_valid_o;
    logic [ADDR_W-1:0]   s_iob_addr_o;
    logic [DATA_W-1:0]   s_iob_wdata_o;
    logic [DATA_W/8-1:0] s_iob_wstrb_o;
    logic                s_iob_rvalid_i;
    logic [DATA_W-1:0]   s_iob_rdata_i;
    logic                s_iob_ready_i;

    always #5 clk_i = ~clk_i;

    iob_cache_be_arbiter dut (
        .clk_i(clk_i), .cke_i(cke_i), .rst_i(rst_i),
        .m0_iob_valid_i(m0_iob_valid_i), .m0_iob_addr_i(m0_iob_addr_i),
        .m0_iob_wdata_i(m0_iob_wdata_i), .m0_iob_wstrb_i(m0_iob_wstrb_i),
        .m0_iob_rvalid_o(m0_iob_rvalid_o), .m0_iob_rdata_o(m0_iob_rdata_o),
        .m0_iob_ready_o(m0_iob_ready_o),
        .m1_iob_valid_i(m1_iob_valid_i), .m1_iob_addr_i(m1_iob_addr_i),
        .m1_iob_wdata_i(m1_iob_wdata_i), .m1_iob_wstrb_i(m1_iob_wstrb_i),
        .m1_iob_rvalid_o(m1_iob_rvalid_o), .m1_iob_rdata_o(m1_iob_rdata_o),
        .m1_iob_ready_o(m1_iob_ready_o),
        .s_iob_valid_o(s_iob_valid_o), .s_iob_addr_o(s_iob_addr_o),
        .s_iob_wdata_o(s_iob_wdata_o), .s_iob_wstrb_o(s_iob_wstrb_o),
        .s_iob_rvalid_i(s_iob_rvalid_i), .s_iob_rdata_i(s_iob_rdata_i),
        .s_iob_ready_i(s_iob_ready_i)
    );

    int n_checks;
    int n_errors;

    // Reference model: arbitration memory, outstanding-read owners, memory-side queue
    // of accepted read addresses and per-manager expected read data.
    bit          m_lock, m_lock_id, m_last;
    bit          m_q[$];
    logic [31:0] mem_q[$];
    logic [31:0] exp_q0[$];
    logic [31:0] exp_q1[$];

    bit          e_sv, e_rdy0, e_rdy1, e_rv0, e_rv1, e_g, e_rd;
    logic [31:0] e_addr;

    function automatic logic [31:0] rd_fn(input logic [31:0] a);
        return {a[15:0], ~a[15:0]} ^ 32'h3C3C_0000;
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic eval();
        bit v0, v1, gv, full;
        logic [3:0] strb;
        logic [31:0] wd;
        #2;
        v0 = m0_iob_valid_i;
        v1 = m1_iob_valid_i;
        if (m_lock)        e_g = m_lock_id;
        else if (v0 && v1) e_g = ~m_last;
        else if (v0)       e_g = 1'b0;
        else               e_g = 1'b1;
        gv     = e_g ? v1 : v0;
        strb   = e_g ? m1_iob_wstrb_i : m0_iob_wstrb_i;
        e_addr = e_g ? m1_iob_addr_i : m0_iob_addr_i;
        wd     = e_g ? m1_iob_wdata_i : m0_iob_wdata_i;
        e_rd   = (strb == 4'h0);
        full   = (m_q.size() == DEPTH);
        e_sv   = gv && !(e_rd && full);
        e_rdy0 = e_sv && s_iob_ready_i && !e_g;
        e_rdy1 = e_sv && s_iob_ready_i && e_g;
        e_rv0  = s_iob_rvalid_i && (m_q.size() > 0) && (m_q[0] == 1'b0);
        e_rv1  = s_iob_rvalid_i && (m_q.size() > 0) && (m_q[0] == 1'b1);
        if (!rst_i) begin
            check_eq("s_valid", s_iob_valid_o, e_sv);
            check_eq("m0_ready", m0_iob_ready_o, e_rdy0);
            check_eq("m1_ready", m1_iob_ready_o, e_rdy1);
            check_eq("m0_rvalid", m0_iob_rvalid_o, e_rv0);
            check_eq("m1_rvalid", m1_iob_rvalid_o, e_rv1);
            if (e_sv) begin
                check_eq("s_addr", s_iob_addr_o, e_addr);
                check_eq("s_wdata", s_iob_wdata_o, wd);
                check_eq("s_wstrb", s_iob_wstrb_o, strb);
            end
            if (e_rv0) check_eq("m0_rdata", m0_iob_rdata_o, exp_q0[0]);
            if (e_rv1) check_eq("m1_rdata", m1_iob_rdata_o, exp_q1[0]);
            if (s_iob_rvalid_i) begin
                check_eq("m0_rdata_bcast", m0_iob_rdata_o, s_iob_rdata_i);
                check_eq("m1_rdata_bcast", m1_iob_rdata_o, s_iob_rdata_i);
            end
        end
    endtask

    task automatic adv();
        @(posedge clk_i);
        if (rst_i) begin
            m_lock = 0; m_lock_id = 0; m_last = 1;
            m_q.delete(); mem_q.delete(); exp_q0.delete(); exp_q1.delete();
        end else if (cke_i) begin
            if (e_rv0 || e_rv1) begin
                void'(m_q.pop_front());
                void'(mem_q.pop_front());
                if (e_rv0) void'(exp_q0.pop_front());
                else       void'(exp_q1.pop_front());
            end
            if (e_sv && s_iob_ready_i) begin
                m_lock = 0;
                m_last = e_g;
                if (e_rd) begin
                    m_q.push_back(e_g);
                    mem_q.push_back(e_addr);
                    if (e_g) exp_q1.push_back(rd_fn(e_addr));
                    else     exp_q0.push_back(rd_fn(e_addr));
                end
            end else if (e_sv) begin
                m_lock = 1;
                m_lock_id = e_g;
            end
        end
        #1;
    endtask

    task automatic cycle();
        eval();
        adv();
    endtask

    task automatic set_req(input bit p, input bit v, input logic [31:0] a, input logic [3:0] s);
        if (!p) begin
            m0_iob_valid_i = v; m0_iob_addr_i = a; m0_iob_wstrb_i = s; m0_iob_wdata_i = $urandom;
        end else begin
            m1_iob_valid_i = v; m1_iob_addr_i = a; m1_iob_wstrb_i = s; m1_iob_wdata_i = $urandom;
        end
    endtask

    task automatic set_rsp(input bit en);
        s_iob_rvalid_i = en && (mem_q.size() > 0);
        if (s_iob_rvalid_i) s_iob_rdata_i = rd_fn(mem_q[0]);
        else                s_iob_rdata_i = $urandom;
    endtask

    task automatic idle();
        set_req(0, 0, 0, 0);
        set_req(1, 0, 0, 0);
        s_iob_ready_i = 1;
        set_rsp(0);
    endtask

    task automatic drain();
        idle();
        for (int i = 0; i < 16 && mem_q.size() > 0; i++) begin
            set_rsp(1);
            cycle();
        end
        set_rsp(0);
        check_eq("drain_empty", mem_q.size(), 0);
    endtask

    initial begin
        #400000;
        $display("FAIL timeout: simulation did not finish, errors so far %0d", n_errors);
        $fatal(1);
    end

    initial begin
        bit h0, h1, a0, a1;
        n_checks = 0; n_errors = 0;
        m_lock = 0; m_lock_id = 0; m_last = 1;
        cke_i = 1; rst_i = 1;
        idle();
        repeat (3) cycle();
        rst_i = 0;

        // Reset state
        eval();
        check_eq("rst_s_valid", s_iob_valid_o, 0);
        check_eq("rst_m0_ready", m0_iob_ready_o, 0);
        check_eq("rst_m1_ready", m1_iob_ready_o, 0);
        check_eq("rst_m0_rvalid", m0_iob_rvalid_o, 0);
        check_eq("rst_m1_rvalid", m1_iob_rvalid_o, 0);
        adv();

        // Tie: m0 first after reset, then m1, then m0
        set_req(0, 1, 32'h10, 0); set_req(1, 1, 32'h14, 0);
        eval(); check_eq("tie_c0_m0", m0_iob_ready_o, 1); check_eq("tie_c0_m1", m1_iob_ready_o, 0); adv();
        set_req(0, 1, 32'h18, 0);
        eval(); check_eq("tie_c1_m1", m1_iob_ready_o, 1); check_eq("tie_c1_m0", m0_iob_ready_o, 0); adv();
        set_req(1, 1, 32'h1C, 0);
        eval(); check_eq("tie_c2_m0", m0_iob_ready_o, 1); check_eq("tie_c2_addr", s_iob_addr_o, 32'h18); adv();
        drain();

        // Lock: make m1 the last winner so an unlocked tie would pick m0
        set_req(1, 1, 32'h180, 0);
        eval(); check_eq("lock_pre_m1", m1_iob_ready_o, 1); adv();
        s_iob_ready_i = 0; set_req(1, 1, 32'h100, 4'hF);
        eval(); check_eq("lock_c0_addr", s_iob_addr_o, 32'h100); adv();
        set_req(0, 1, 32'h200, 0);
        eval(); check_eq("lock_c1_addr", s_iob_addr_o, 32'h100); adv();
        eval(); check_eq("lock_c2_addr", s_iob_addr_o, 32'h100); adv();
        s_iob_ready_i = 1;
        eval(); check_eq("lock_c3_addr", s_iob_addr_o, 32'h100); check_eq("lock_c3_m1", m1_iob_ready_o, 1); adv();
        set_req(1, 0, 0, 0);
        eval(); check_eq("lock_c4_addr", s_iob_addr_o, 32'h200); check_eq("lock_c4_m0", m0_iob_ready_o, 1); adv();
        drain();

        // Steering
        set_req(0, 1, 32'h40, 0); cycle();
        set_req(0, 0, 0, 0); set_req(1, 1, 32'h80, 0); cycle();
        set_req(1, 0, 0, 0); set_req(0, 1, 32'hC0, 0); cycle();
        idle(); set_rsp(1);
        eval(); check_eq("steer_a_m0", m0_iob_rvalid_o, 1); check_eq("steer_a_data", m0_iob_rdata_o, rd_fn(32'h40)); adv();
        set_rsp(1);
        eval(); check_eq("steer_b_m1", m1_iob_rvalid_o, 1); check_eq("steer_b_m0", m0_iob_rvalid_o, 0);
        check_eq("steer_b_data", m1_iob_rdata_o, rd_fn(32'h80)); adv();
        set_rsp(1);
        eval(); check_eq("steer_c_m0", m0_iob_rvalid_o, 1); check_eq("steer_c_data", m0_iob_rdata_o, rd_fn(32'hC0)); adv();
        set_rsp(0);

        // Full FIFO
        for (int i = 0; i < 4; i++) begin
            set_req(0, 1, 32'h1000 + 32'(4 * i), 0);
            eval(); check_eq("full_acc", m0_iob_ready_o, 1); adv();
        end
        set_req(0, 1, 32'h1010, 0);
        eval(); check_eq("full_blk_valid", s_iob_valid_o, 0); check_eq("full_blk_m0", m0_iob_ready_o, 0); adv();
        set_req(1, 1, 32'h2000, 4'h3);
        eval(); check_eq("full_wr_m1", m1_iob_ready_o, 1); check_eq("full_wr_strb", s_iob_wstrb_o, 4'h3); adv();
        set_req(1, 0, 0, 0); set_rsp(1);
        eval(); check_eq("full_pop_blk", s_iob_valid_o, 0); check_eq("full_pop_m0", m0_iob_rvalid_o, 1); adv();
        set_rsp(0);
        eval(); check_eq("full_5th_m0", m0_iob_ready_o, 1); check_eq("full_5th_addr", s_iob_addr_o, 32'h1010); adv();
        drain();

        // Push and pop in the same cycle
        set_req(0, 1, 32'h3000, 0); cycle();
        set_req(0, 1, 32'h3004, 0); cycle();
        set_req(0, 0, 0, 0); set_req(1, 1, 32'h300, 0); set_rsp(1);
        eval(); check_eq("pp_m1_ready", m1_iob_ready_o, 1); check_eq("pp_m0_rvalid", m0_iob_rvalid_o, 1); adv();
        set_req(1, 0, 0, 0); set_rsp(1);
        eval(); check_eq("pp_2_m0", m0_iob_rvalid_o, 1); check_eq("pp_2_data", m0_iob_rdata_o, rd_fn(32'h3004)); adv();
        set_rsp(1);
        eval(); check_eq("pp_3_m1", m1_iob_rvalid_o, 1); check_eq("pp_3_data", m1_iob_rdata_o, rd_fn(32'h300)); adv();
        set_rsp(0);

        // Reset with reads outstanding
        set_req(1, 1, 32'h500, 0); cycle();
        set_req(1, 1, 32'h504, 0); cycle();
        idle(); rst_i = 1; cycle(); rst_i = 0;
        set_req(0, 1, 32'h600, 0);
        eval(); check_eq("rst2_m0_ready", m0_iob_ready_o, 1); adv();
        idle(); set_rsp(1);
        eval(); check_eq("rst2_m0_rvalid", m0_iob_rvalid_o, 1); check_eq("rst2_m1_rvalid", m1_iob_rvalid_o, 0); adv();
        set_rsp(0);

        // Clock enable low holds lock and FIFO
        set_req(0, 1, 32'h700, 0); cycle();
        s_iob_ready_i = 0; set_req(0, 1, 32'h710, 4'hF); cycle();
        set_req(1, 1, 32'h720, 0); cke_i = 0;
        repeat (5) begin
            eval(); check_eq("cke_addr", s_iob_addr_o, 32'h710); adv();
        end
        cke_i = 1; s_iob_ready_i = 1;
        eval(); check_eq("cke_m0_ready", m0_iob_ready_o, 1); adv();
        set_req(0, 0, 0, 0);
        eval(); check_eq("cke_m1_ready", m1_iob_ready_o, 1); adv();
        drain();

        // Random traffic
        h0 = 0; h1 = 0;
        repeat (3000) begin
            if (!h0 && $urandom_range(0, 2) == 0) begin
                set_req(0, 1, 32'($urandom_range(0, 1023)) << 2,
                        $urandom_range(0, 1) ? 4'h0 : 4'($urandom_range(1, 15)));
                h0 = 1;
            end
            if (!h1 && $urandom_range(0, 2) == 0) begin
                set_req(1, 1, 32'($urandom_range(0, 1023)) << 2,
                        $urandom_range(0, 1) ? 4'h0 : 4'($urandom_range(1, 15)));
                h1 = 1;
            end
            cke_i = ($urandom_range(0, 19) != 0);
            s_iob_ready_i = cke_i && ($urandom_range(0, 9) < 7);
            set_rsp(cke_i && ($urandom_range(0, 1) == 1));
            eval();
            a0 = e_rdy0;
            a1 = e_rdy1;
            adv();
            if (a0) begin h0 = 0; m0_iob_valid_i = 0; end
            if (a1) begin h1 = 0; m1_iob_valid_i = 0; end
        end
        cke_i = 1;
        drain();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
